// File: rtl/outport_rr_arbiter.sv
// -----------------------------------------------------------------------------
// outport_rr_arbiter
//
// Output-port controller for one router link (CW, CCW or PE). There are two
// virtual channels (even and odd) that work independently. Each VC has:
//   - a single-entry output buffer,
//   - a round-robin pointer that shares the VC between NUM_REQ input modules.
// The polarity input decides which VC may use the link in a given cycle.
//
// Ports
//   clk             clock
//   rst             synchronous reset, active-high
//   polarity        0 = even VC owns the link this cycle, 1 = odd VC
//   req_even/odd    per-requester VC requests (bit i = input module i)
//   din_even/odd    per-requester flits, requester i at [i*DATA_WIDTH +: DATA_WIDTH]
//   grant_even/odd  one-hot (or zero) grant, combinational, 1-cycle pulse
//   ri              downstream ready for the VC selected by polarity
//   so              send strobe to the downstream link
//   dout            flit on the link (zero when so = 0)
//   grant_cnt_even/odd  saturating grant counters (OUTARB_GRANT_CNT_EN only)
//
// Optional feature macro: OUTARB_GRANT_CNT_EN adds the two grant counters.
// -----------------------------------------------------------------------------
module outport_rr_arbiter #(
   parameter int DATA_WIDTH = 64,
   parameter int NUM_REQ    = 3,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          polarity,
   input  logic [NUM_REQ-1:0]            req_even,
   input  logic [NUM_REQ-1:0]            req_odd,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] din_even,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] din_odd,
   output logic [NUM_REQ-1:0]            grant_even,
   output logic [NUM_REQ-1:0]            grant_odd,
   input  logic                          ri,
   output logic                          so,
   output logic [DATA_WIDTH-1:0]         dout
`ifdef OUTARB_GRANT_CNT_EN
   ,
   output logic [CNT_WIDTH-1:0]          grant_cnt_even,
   output logic [CNT_WIDTH-1:0]          grant_cnt_odd
`endif
);

   localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   // VC-indexed views of the ports: index 0 = even, index 1 = odd.
   logic [1:0][NUM_REQ-1:0]            req_vc;
   logic [1:0][NUM_REQ*DATA_WIDTH-1:0] din_vc;
   logic [1:0][NUM_REQ-1:0]            grant_vc;
   logic [1:0]                         full_vc;
   logic [1:0][DATA_WIDTH-1:0]         buf_vc;

   assign req_vc[0]  = req_even;
   assign req_vc[1]  = req_odd;
   assign din_vc[0]  = din_even;
   assign din_vc[1]  = din_odd;
   assign grant_even = grant_vc[0];
   assign grant_odd  = grant_vc[1];

   // Round-robin pick: first set request at or above ptr, wrapping around.
   // Returns {found, index}.
   function automatic logic [PTR_W:0] rr_pick(input logic [NUM_REQ-1:0] req,
                                              input logic [PTR_W-1:0]   ptr);
      logic [PTR_W:0] res;
      int             idx;
      res = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         idx = (int'(ptr) + k) % NUM_REQ;
         if (!res[PTR_W] && req[idx[PTR_W-1:0]]) begin
            res = {1'b1, idx[PTR_W-1:0]};
         end
      end
      return res;
   endfunction

   // Link side. A flit leaves when its VC owns the link, the buffer holds a
   // flit and downstream is ready. Reset suppresses the strobe immediately so
   // a flit being flushed never appears on the link.
   assign so   = !rst && ri && full_vc[polarity];
   assign dout = so ? buf_vc[polarity] : '0;

`ifdef OUTARB_GRANT_CNT_EN
   logic [1:0][CNT_WIDTH-1:0] cnt_vc;
   assign grant_cnt_even = cnt_vc[0];
   assign grant_cnt_odd  = cnt_vc[1];
`endif

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_vc
         logic [DATA_WIDTH-1:0] buf_q,  buf_d;
         logic                  full_q, full_d;
         logic [PTR_W-1:0]      ptr_q,  ptr_d;
         logic [PTR_W:0]        pick;
         logic [PTR_W-1:0]      win;
         logic [PTR_W-1:0]      ptr_inc;
         logic                  grant_any;
         logic                  drain;

         assign pick = rr_pick(req_vc[gi], ptr_q);
         assign win  = pick[PTR_W-1:0];

         // Fill only from an empty buffer at the start of the cycle; a buffer
         // that is draining this cycle still reads full, hence one bubble.
         assign grant_any    = !rst && !full_q && pick[PTR_W];
         assign grant_vc[gi] = grant_any ? (NUM_REQ'(1) << win) : '0;
         assign drain        = so && (polarity == gi[0]);

         assign full_vc[gi] = full_q;
         assign buf_vc[gi]  = buf_q;

         always_comb begin
            ptr_inc = (win == PTR_W'(NUM_REQ - 1)) ? '0 : win + PTR_W'(1);
            buf_d   = buf_q;
            full_d  = full_q;
            ptr_d   = ptr_q;
            if (grant_any) begin
               buf_d  = din_vc[gi][win*DATA_WIDTH +: DATA_WIDTH];
               full_d = 1'b1;
               ptr_d  = ptr_inc;
            end else if (drain) begin
               full_d = 1'b0;
            end
         end

         always_ff @(posedge clk) begin
            if (rst) begin
               buf_q  <= '0;
               full_q <= 1'b0;
               ptr_q  <= '0;
            end else begin
               buf_q  <= buf_d;
               full_q <= full_d;
               ptr_q  <= ptr_d;
            end
         end

`ifdef OUTARB_GRANT_CNT_EN
         logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

         always_comb begin
            cnt_d = cnt_q;
            if (grant_any && (cnt_q != '1)) begin
               cnt_d = cnt_q + CNT_WIDTH'(1);
            end
         end

         always_ff @(posedge clk) begin
            if (rst) begin
               cnt_q <= '0;
            end else begin
               cnt_q <= cnt_d;
            end
         end

         assign cnt_vc[gi] = cnt_q;
`endif
      end
   endgenerate

endmodule

// File: tb/tb_outport_rr_arbiter.sv
module tb_outport_rr_arbiter;

   localparam int DW = 64;
   localparam int NR = 3;

   logic             clk = 1'b0;
   logic             rst;
   logic             polarity;
   logic [NR-1:0]    req_even, req_odd;
   logic [NR*DW-1:0] din_even, din_odd;
   logic [NR-1:0]    grant_even, grant_odd;
   logic             ri;
   logic             so;
   logic [DW-1:0]    dout;
`ifdef OUTARB_GRANT_CNT_EN
   logic [15:0]      grant_cnt_even, grant_cnt_odd;
`endif

   int checks = 0;
   int errors = 0;

   outport_rr_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(NR), .CNT_WIDTH(16)) dut (
      .clk        (clk),
      .rst        (rst),
      .polarity   (polarity),
      .req_even   (req_even),
      .req_odd    (req_odd),
      .din_even   (din_even),
      .din_odd    (din_odd),
      .grant_even (grant_even),
      .grant_odd  (grant_odd),
      .ri         (ri),
      .so         (so),
      .dout       (dout)
`ifdef OUTARB_GRANT_CNT_EN
      ,
      .grant_cnt_even (grant_cnt_even),
      .grant_cnt_odd  (grant_cnt_odd)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Inputs are changed 1 time unit after a rising edge; outputs are sampled
   // on the following falling edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      @(negedge clk);
   endtask

   // Expected values for the round-robin phase (polarity 0,1,0,1,...).
   logic [2:0]  rr_grant [8] = '{3'b001, 3'b000, 3'b000, 3'b010, 3'b000, 3'b100, 3'b000, 3'b001};
   logic        rr_so    [8] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
   logic [63:0] rr_dout  [8] = '{64'h0, 64'h0, 64'hA5, 64'h0, 64'hE1, 64'h0, 64'hE2, 64'h0};

   initial begin
      rst      = 1'b1;
      polarity = 1'b0;
      req_even = 3'b111;
      req_odd  = 3'b111;
      ri       = 1'b1;
      din_even = {64'hE2, 64'hE1, 64'hA5};
      din_odd  = {64'hD2, 64'hD1, 64'hD0};

      // 1. Reset with all requests high
      for (int c = 0; c < 2; c++) begin
         tick();
         settle();
         chk("rst_grant_even", grant_even, 3'b000);
         chk("rst_grant_odd", grant_odd, 3'b000);
         chk("rst_so", so, 1'b0);
         chk("rst_dout", dout, 64'h0);
         $display("reset cycle %0d: grant_even=%b grant_odd=%b so=%b", c, grant_even, grant_odd, so);
      end
`ifdef OUTARB_GRANT_CNT_EN
      chk("rst_cnt_even", grant_cnt_even, 16'd0);
      chk("rst_cnt_odd", grant_cnt_odd, 16'd0);
`endif
      tick();
      rst      = 1'b0;
      req_even = 3'b001;
      req_odd  = 3'b000;

      // 2. Even only: same-cycle grant, flit on the next even cycle
      settle();
      chk("even_grant", grant_even, 3'b001);
      chk("even_so_c0", so, 1'b0);
      $display("even c0: grant_even=%b so=%b", grant_even, so);
      tick();
      req_even = 3'b000;
      settle();
      chk("even_so_c1", so, 1'b1);
      chk("even_dout_c1", dout, 64'hA5);
      chk("even_nogrant_c1", grant_even, 3'b000);
      $display("even c1: so=%b dout=%0h", so, dout);
      tick();
      settle();
      chk("even_so_c2", so, 1'b0);
      chk("even_dout_c2", dout, 64'h0);

      // 3. Round-robin from a freshly reset pointer
      tick();
      rst = 1'b1;
      tick();
      rst      = 1'b0;
      req_even = 3'b111;
      for (int c = 0; c < 8; c++) begin
         polarity = c[0];
         settle();
         chk("rr_grant", grant_even, rr_grant[c]);
         chk("rr_so", so, rr_so[c]);
         chk("rr_dout", dout, rr_dout[c]);
         $display("rr c%0d: pol=%b grant_even=%b so=%b dout=%0h", c, polarity, grant_even, so, dout);
         tick();
      end
      // even buffer now holds A5, pointer at 1

      // 4. Backpressure
      polarity = 1'b0;
      ri       = 1'b0;
      for (int c = 0; c < 5; c++) begin
         settle();
         chk("bp_so", so, 1'b0);
         chk("bp_dout", dout, 64'h0);
         chk("bp_grant", grant_even, 3'b000);
         $display("bp c%0d: so=%b grant_even=%b", c, so, grant_even);
         tick();
      end
      ri = 1'b1;
      settle();
      chk("bp_release_so", so, 1'b1);
      chk("bp_release_dout", dout, 64'hA5);
      chk("bp_release_grant", grant_even, 3'b000);
      $display("bp release: so=%b dout=%0h", so, dout);
      tick();
      settle();
      chk("bp_resume_grant", grant_even, 3'b010);
      chk("bp_resume_so", so, 1'b0);
      $display("bp resume: grant_even=%b", grant_even);
      tick();
      req_even = 3'b000;
      settle();
      chk("bp_drain_dout", dout, 64'hE1);
      tick();
      // even pointer at 2, both buffers empty

      // 5. VC independence
      req_even = 3'b010;
      req_odd  = 3'b100;
      polarity = 1'b0;
      settle();
      chk("vc_grant_even", grant_even, 3'b010);
      chk("vc_grant_odd", grant_odd, 3'b100);
      $display("vc: grant_even=%b grant_odd=%b", grant_even, grant_odd);
      tick();
      req_even = 3'b000;
      req_odd  = 3'b000;
      settle();
      chk("vc_even_so", so, 1'b1);
      chk("vc_even_dout", dout, 64'hE1);
      tick();
      polarity = 1'b1;
      settle();
      chk("vc_odd_so", so, 1'b1);
      chk("vc_odd_dout", dout, 64'hD2);
      $display("vc odd: so=%b dout=%0h", so, dout);
      tick();
      settle();
      chk("vc_odd_empty", so, 1'b0);
      tick();

      // 6. Reset mid-transfer with both buffers full
      req_even = 3'b001;
      req_odd  = 3'b001;
      polarity = 1'b0;
      ri       = 1'b0;
      settle();
      chk("fill_grant_even", grant_even, 3'b001);
      chk("fill_grant_odd", grant_odd, 3'b001);
      tick();
      settle();
      chk("full_hold_so", so, 1'b0);
`ifdef OUTARB_GRANT_CNT_EN
      chk("cnt_even", grant_cnt_even, 16'd7);
      chk("cnt_odd", grant_cnt_odd, 16'd2);
`endif
      tick();
      rst      = 1'b1;
      ri       = 1'b1;
      req_even = 3'b111;
      req_odd  = 3'b111;
      settle();
      chk("midrst_grant_even", grant_even, 3'b000);
      chk("midrst_grant_odd", grant_odd, 3'b000);
      chk("midrst_so", so, 1'b0);
      $display("mid-reset: grant_even=%b grant_odd=%b so=%b", grant_even, grant_odd, so);
      tick();
      rst      = 1'b0;
      req_even = 3'b000;
      req_odd  = 3'b000;
      polarity = 1'b0;
      settle();
      chk("post_rst_so_even", so, 1'b0);
`ifdef OUTARB_GRANT_CNT_EN
      chk("post_rst_cnt_even", grant_cnt_even, 16'd0);
      chk("post_rst_cnt_odd", grant_cnt_odd, 16'd0);
`endif
      tick();
      polarity = 1'b1;
      settle();
      chk("post_rst_so_odd", so, 1'b0);
      chk("post_rst_dout", dout, 64'h0);
      $display("post-reset: so=%b dout=%0h", so, dout);
      tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
